ram_burst_arbiter: RTL

Sequences a single-port DATA_SIZE-wide RAM of 2**ROW_W rows x 2**COL_W words. The RAM is shared between one row-writer client and one row-reader client, with row-granular bursts. The block owns all RAM addressing and treats rows as a ring buffer, so reads never overtake writes. It sits between the producer and consumer logic and the RAM macro, and drives the RAM's write-enable, row, column and write data.

---
 rtl/ram_arb_pkg.sv | 23 ++
 rtl/ram_row_ring.sv | 58 +++++
 rtl/ram_burst_arbiter.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared types and default widths for the RAM burst arbiter.
//   arb_state_t : burst sequencer states (IDLE, WRITE, READ, DRAIN)
//   grant_t     : which client received the most recent grant
//   DEF_*       : default data / row / column widths
package ram_arb_pkg;

  localparam int DEF_DATA_SIZE = 16;
  localparam int DEF_ROW_W     = 5;
  localparam int DEF_COL_W     = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } arb_state_t;

  typedef enum logic {
    GRANT_WR = 1'b0,
    GRANT_RD = 1'b1
  } grant_t;

endpackage

// File: rtl/ram_row_ring.sv
// ram_row_ring: row-granular ring buffer bookkeeping for the shared RAM.
// Ports:
//   i_clock      system clock, rising edge
//   i_reset      synchronous active-low reset
//   i_push       one full row has been written
//   i_pop        one full row has been read
//   o_wr_row     next row to be written
//   o_rd_row     next row to be read
//   o_row_count  rows written but not yet read (0 .. 2**ROW_W)
//   o_full       all rows hold unread data
//   o_empty      no unread rows
module ram_row_ring
  import ram_arb_pkg::*;
#(
  parameter int ROW_W = DEF_ROW_W
) (
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic             i_pop,
  output logic [ROW_W-1:0] o_wr_row,
  output logic [ROW_W-1:0] o_rd_row,
  output logic [ROW_W:0]   o_row_count,
  output logic             o_full,
  output logic             o_empty
);

  localparam logic [ROW_W:0] ROWS = {1'b1, {ROW_W{1'b0}}};

  logic [ROW_W-1:0] r_wr_row;
  logic [ROW_W-1:0] r_rd_row;
  logic [ROW_W:0]   r_row_count;

  // Row pointers wrap silently; the count is one bit wider so that a
  // completely full ring is distinguishable from an empty one.
  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_wr_row    <= '0;
      r_rd_row    <= '0;
      r_row_count <= '0;
    end else begin
      if (i_push) r_wr_row <= r_wr_row + 1'b1;
      if (i_pop)  r_rd_row <= r_rd_row + 1'b1;
      case ({i_push, i_pop})
        2'b10:   r_row_count <= r_row_count + 1'b1;
        2'b01:   r_row_count <= r_row_count - 1'b1;
        default: r_row_count <= r_row_count;
      endcase
    end
  end

  assign o_wr_row    = r_wr_row;
  assign o_rd_row    = r_rd_row;
  assign o_row_count = r_row_count;
  assign o_full      = (r_row_count == ROWS);
  assign o_empty     = (r_row_count == '0);

endmodule

// File: rtl/ram_burst_arbiter.sv
// ram_burst_arbiter: sequences a single-port RAM shared by one row writer
// and one row reader. Every access is a full-row burst of 2**COL_W words;
// rows form a ring so the reader never overtakes the writer.
// Ports:
//   i_clock, i_reset             clock, synchronous active-low reset
//   i_wr_req                     writer wants to write one row
//   i_wr_valid, i_wr_data        write word, accepted when o_wr_ready
//   o_wr_ready                   high for the whole write burst
//   i_rd_req                     reader wants one row
//   o_rd_valid, o_rd_data        read word stream, no backpressure
//   o_rd_last                    marks the final word of a row
//   o_ram_we, o_ram_re           RAM write / read strobes (exclusive)
//   o_ram_row, o_ram_col         RAM address
//   o_ram_wdata, i_ram_rdata     RAM data (read data one cycle after o_ram_re)
//   o_row_count, o_full, o_empty ring occupancy
//   o_status_change              one-cycle pulse after each completed burst
module ram_burst_arbiter
  import ram_arb_pkg::*;
#(
  parameter int DATA_SIZE = DEF_DATA_SIZE,
  parameter int ROW_W     = DEF_ROW_W,
  parameter int COL_W     = DEF_COL_W
) (
  input  logic                 i_clock,
  input  logic                 i_reset,
  input  logic                 i_wr_req,
  input  logic                 i_wr_valid,
  input  logic [DATA_SIZE-1:0] i_wr_data,
  output logic                 o_wr_ready,
  input  logic                 i_rd_req,
  output logic                 o_rd_valid,
  output logic [DATA_SIZE-1:0] o_rd_data,
  output logic                 o_rd_last,
  output logic                 o_ram_we,
  output logic                 o_ram_re,
  output logic [ROW_W-1:0]     o_ram_row,
  output logic [COL_W-1:0]     o_ram_col,
  output logic [DATA_SIZE-1:0] o_ram_wdata,
  input  logic [DATA_SIZE-1:0] i_ram_rdata,
  output logic [ROW_W:0]       o_row_count,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_status_change
);

  arb_state_t       r_state;
  arb_state_t       w_state_next;
  logic [COL_W-1:0] r_col;
  logic [COL_W-1:0] w_col_next;
  grant_t           r_last_grant;
  grant_t           w_last_grant_next;
  logic             r_status_change;
  logic             r_rd_valid;
  logic             r_rd_last;

  logic [ROW_W-1:0] w_wr_row;
  logic [ROW_W-1:0] w_rd_row;
  logic             w_full;
  logic             w_empty;
  logic             w_col_max;
  logic             w_write_ok;
  logic             w_read_ok;
  logic             w_push;
  logic             w_pop;

  assign w_col_max  = (r_col == {COL_W{1'b1}});
  assign w_write_ok = i_wr_req && !w_full;
  assign w_read_ok  = i_rd_req && !w_empty;

  // A row is committed only when its last word is accepted, so a burst cut
  // short by reset leaves the ring untouched.
  assign w_push = (r_state == WRITE) && i_wr_valid && w_col_max;
  assign w_pop  = (r_state == READ) && w_col_max;

  ram_row_ring #(
    .ROW_W (ROW_W)
  ) u_ring (
    .i_clock     (i_clock),
    .i_reset     (i_reset),
    .i_push      (w_push),
    .i_pop       (w_pop),
    .o_wr_row    (w_wr_row),
    .o_rd_row    (w_rd_row),
    .o_row_count (o_row_count),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      r_state         <= IDLE;
      r_col           <= '0;
      r_last_grant    <= GRANT_RD;
      r_status_change <= 1'b0;
      r_rd_valid      <= 1'b0;
      r_rd_last       <= 1'b0;
    end else begin
      r_state         <= w_state_next;
      r_col           <= w_col_next;
      r_last_grant    <= w_last_grant_next;
      // Write bursts report as they return to IDLE; read bursts report one
      // cycle later, after DRAIN has delivered the final word.
      r_status_change <= w_push || (r_state == DRAIN);
      r_rd_valid      <= (r_state == READ);
      r_rd_last       <= w_pop;
    end
  end

  always_comb begin
    w_state_next      = r_state;
    w_col_next        = r_col;
    w_last_grant_next = r_last_grant;
    o_wr_ready        = 1'b0;
    o_ram_we          = 1'b0;
    o_ram_re          = 1'b0;
    o_ram_row         = '0;
    o_ram_col         = '0;
    o_ram_wdata       = '0;
    case (r_state)
      IDLE: begin
        w_col_next = '0;
        // Round-robin only matters on a tie; a lone eligible client wins.
        if (w_write_ok && (!w_read_ok || (r_last_grant == GRANT_RD))) begin
          w_state_next      = WRITE;
          w_last_grant_next = GRANT_WR;
        end else if (w_read_ok) begin
          w_state_next      = READ;
          w_last_grant_next = GRANT_RD;
        end
      end
      WRITE: begin
        o_wr_ready  = 1'b1;
        o_ram_we    = i_wr_valid;
        o_ram_wdata = i_wr_data;
        o_ram_row   = w_wr_row;
        o_ram_col   = r_col;
        if (i_wr_valid) begin
          w_col_next = r_col + 1'b1;
          if (w_col_max) w_state_next = IDLE;
        end
      end
      READ: begin
        o_ram_re   = 1'b1;
        o_ram_row  = w_rd_row;
        o_ram_col  = r_col;
        w_col_next = r_col + 1'b1;
        if (w_col_max) w_state_next = DRAIN;
      end
      DRAIN: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // The RAM presents data the cycle after o_ram_re, which is exactly the
  // cycle r_rd_valid is high, so the data passes straight through qualified
  // by the registered valid.
  assign o_rd_valid      = r_rd_valid;
  assign o_rd_data       = r_rd_valid ? i_ram_rdata : '0;
  assign o_rd_last       = r_rd_last;
  assign o_full          = w_full;
  assign o_empty         = w_empty;
  assign o_status_change = r_status_change;

endmodule
